// File: rtl/inst_encoder_loader.sv
// Instruction encoder and program loader: packs field sets into 8-bit words,
// stages them in a small FIFO and streams them into instruction memory.
module inst_encoder_loader #(
    parameter int PROG_DEPTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    op,
    input  logic [1:0]    dest_addr,
    input  logic [1:0]    src1_addr,
    input  logic [1:0]    src2_addr,
    input  logic          in_last,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          done,
    output logic [AW:0]   inst_count
);

    localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [AW:0]    PROG_MAX = (AW+1)'(PROG_DEPTH);
    localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
    localparam logic [FAW:0]   FIFO_MAX = (FAW+1)'(FIFO_DEPTH);
    localparam logic [FAW:0]   FCNT_ONE = (FAW+1)'(1);
    localparam logic [FAW-1:0] PTR_ONE  = FAW'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [7:0]     fifo_mem [FIFO_DEPTH];
    logic [FAW-1:0] rd_ptr;
    logic [FAW-1:0] wr_ptr;
    logic [FAW:0]   fifo_count;
    logic [AW:0]    accepted;
    logic           last_seen;
    logic           push;
    logic           pop;
    logic           begin_load;

    // start only matters outside LOAD; a pulse mid-load is dropped
    assign begin_load = start && (state != LOAD);

    assign in_ready = (state == LOAD) && (fifo_count < FIFO_MAX)
                      && !last_seen && (accepted < PROG_MAX);

    assign push = in_valid && in_ready;
    assign pop  = (state == LOAD) && (fifo_count != '0);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                // an empty FIFO implies no pop this cycle
                if ((fifo_count == '0) &&
                    (last_seen || (accepted == PROG_MAX)))
                    state_nxt = DONE;
            end
            DONE: begin
                if (start) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {op, dest_addr, src1_addr, src2_addr};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            accepted   <= '0;
            last_seen  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            inst_count <= '0;
        end else begin
            mem_we <= 1'b0;
            if (begin_load) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                fifo_count <= '0;
                accepted   <= '0;
                last_seen  <= 1'b0;
                mem_addr   <= '0;
                inst_count <= '0;
            end else begin
                if (push) begin
                    wr_ptr   <= wr_ptr + PTR_ONE;
                    accepted <= accepted + CNT_ONE;
                    if (in_last) last_seen <= 1'b1;
                end
                if (pop) begin
                    rd_ptr     <= rd_ptr + PTR_ONE;
                    mem_we     <= 1'b1;
                    mem_wdata  <= fifo_mem[rd_ptr];
                    mem_addr   <= inst_count[AW-1:0];
                    inst_count <= inst_count + CNT_ONE;
                end
                if (push && !pop) begin
                    fifo_count <= fifo_count + FCNT_ONE;
                end else if (pop && !push) begin
                    fifo_count <= fifo_count - FCNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Bench for inst_encoder_loader: vector table plus scoreboard of
// expected memory writes, checked whenever mem_we is seen.
module tb_inst_encoder_loader;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic       start     = 1'b0;
    logic       in_valid  = 1'b0;
    logic       in_last   = 1'b0;
    logic [1:0] op        = '0;
    logic [1:0] dest_addr = '0;
    logic [1:0] src1_addr = '0;
    logic [1:0] src2_addr = '0;
    logic       in_ready;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       done;
    logic [4:0] inst_count;

    inst_encoder_loader #(
        .PROG_DEPTH(16),
        .FIFO_DEPTH(4),
        .AW(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .op(op),
        .dest_addr(dest_addr),
        .src1_addr(src1_addr),
        .src2_addr(src2_addr),
        .in_last(in_last),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .done(done),
        .inst_count(inst_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [1:0] dest;
        logic [1:0] src1;
        logic [1:0] src2;
        logic       last;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } exp_t;

    vec_t tbl [8];
    exp_t sbq [$];
    int   wr_cyc [$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   exp_addr = 0;
    int   n_wr     = 0;
    int   n_acc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            n_wr++;
            wr_cyc.push_back(cyc);
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%0d data=%h",
                         mem_addr, mem_wdata);
            end else begin
                mon_e = sbq.pop_front();
                if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.data) begin
                    failures++;
                    $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                             mem_addr, mem_wdata, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, expv);
        end
    endtask

    task automatic offer(input vec_t v, input logic last, output bit took);
        exp_t e;
        @(negedge clk);
        op        = v.op;
        dest_addr = v.dest;
        src1_addr = v.src1;
        src2_addr = v.src2;
        in_last   = last;
        in_valid  = 1'b1;
        took      = (in_ready === 1'b1);
        if (took) begin
            e.addr = 4'(exp_addr);
            e.data = v.exp;
            sbq.push_back(e);
            exp_addr++;
            n_acc++;
        end
    endtask

    task automatic send(input vec_t v, input logic last);
        bit took;
        int g;
        took = 1'b0;
        g    = 0;
        while (!took && g < 50) begin
            offer(v, last, took);
            g++;
        end
        check("send_accept", took, 1);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_start(input bit clr);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (clr) begin
            exp_addr = 0;
            n_wr     = 0;
            n_acc    = 0;
            wr_cyc.delete();
        end
    endtask

    task automatic wait_done(input int exp_cnt, input string nm);
        int g;
        g = 0;
        while (done !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check({nm, "_done"}, done, 1);
        check({nm, "_inst_count"}, inst_count, exp_cnt);
        check({nm, "_sb_empty"}, sbq.size(), 0);
    endtask

    task automatic check_reset_outputs(input string nm);
        check(nm, {in_ready, mem_we, mem_addr, mem_wdata, done, inst_count}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit took;

        tbl[0] = '{2'd1, 2'd2, 2'd3, 2'd0, 1'b1, 8'h6C};
        tbl[1] = '{2'd3, 2'd0, 2'd1, 2'd2, 1'b0, 8'hC6};
        tbl[2] = '{2'd0, 2'd3, 2'd3, 2'd3, 1'b0, 8'h3F};
        tbl[3] = '{2'd2, 2'd1, 2'd0, 2'd1, 1'b0, 8'h91};
        tbl[4] = '{2'd3, 2'd3, 2'd3, 2'd3, 1'b1, 8'hFF};
        tbl[5] = '{2'd0, 2'd0, 2'd0, 2'd1, 1'b0, 8'h01};
        tbl[6] = '{2'd2, 2'd2, 2'd2, 2'd2, 1'b0, 8'hAA};
        tbl[7] = '{2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 8'h40};

        // T1: reset, then a single-instruction program
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("t1_reset_c1");
        @(negedge clk);
        check_reset_outputs("t1_reset_c2");
        reset = 1'b1;
        pulse_start(1);
        send(tbl[0], tbl[0].last);
        idle();
        wait_done(1, "t1");
        check("t1_writes", n_wr, 1);

        // T2: four back-to-back sets from the table
        pulse_start(1);
        for (int i = 1; i <= 4; i++) begin
            send(tbl[i], tbl[i].last);
        end
        idle();
        check("t2_ready_after_last", in_ready, 0);
        wait_done(4, "t2");
        check("t2_writes", wr_cyc.size(), 4);
        if (wr_cyc.size() == 4) begin
            check("t2_consecutive", wr_cyc[3] - wr_cyc[0], 3);
        end

        // T3: 20 offers without last, capacity caps at 16
        pulse_start(1);
        for (int i = 0; i < 20; i++) begin
            offer(tbl[i % 8], 1'b0, took);
            check($sformatf("t3_take_%0d", i), took, (i < 16) ? 1 : 0);
        end
        idle();
        wait_done(16, "t3");
        check("t3_writes", n_wr, 16);

        // T4: in_valid held high across the whole load
        pulse_start(1);
        for (int i = 0; i < 8; i++) begin
            send(tbl[(i + 5) % 8], (i == 7) ? 1'b1 : 1'b0);
        end
        idle();
        wait_done(8, "t4");
        check("t4_writes", n_wr, 8);
        check("t4_acc_eq_wr", n_acc, n_wr);

        // T5: reset mid-load with one word still buffered
        pulse_start(1);
        send(tbl[3], 1'b0);
        send(tbl[6], 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        check("t5_buffered_left", sbq.size(), 1);
        sbq.delete();
        check_reset_outputs("t5_reset_c1");
        @(negedge clk);
        check_reset_outputs("t5_reset_c2");
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_idle_ready", in_ready, 0);
        check("t5_idle_done", done, 0);
        pulse_start(1);
        send(tbl[5], 1'b1);
        idle();
        wait_done(1, "t5");

        // T6: start ignored during LOAD, honoured in DONE
        pulse_start(1);
        send(tbl[5], 1'b0);
        send(tbl[6], 1'b0);
        pulse_start(0);
        send(tbl[7], 1'b0);
        send(tbl[1], 1'b1);
        idle();
        wait_done(4, "t6a");
        pulse_start(1);
        check("t6_done_cleared", done, 0);
        check("t6_count_cleared", inst_count, 0);
        send(tbl[2], 1'b1);
        idle();
        wait_done(1, "t6b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
